// File: rtl/beamform_cfg_pkg.sv
// rtl/beamform_cfg_pkg.sv - tap configuration types, cfg word field positions and FSM states
package beamform_cfg_pkg;

  localparam int CFG_EN_BIT  = 15;
  localparam int CFG_CH_MSB  = 11;
  localparam int CFG_CH_LSB  = 8;
  localparam int CFG_DLY_MSB = 7;
  localparam int CFG_DLY_LSB = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] chan;
    logic [7:0] dly;
  } tap_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2
  } bf_state_t;

  function automatic tap_cfg_t unpack_cfg(input logic [15:0] d);
    tap_cfg_t c;
    c.en   = d[CFG_EN_BIT];
    c.chan = d[CFG_CH_MSB:CFG_CH_LSB];
    c.dly  = d[CFG_DLY_MSB:CFG_DLY_LSB];
    return c;
  endfunction

endpackage

// File: rtl/tap_delay_mux.sv
// rtl/tap_delay_mux.sv - one tap: pick a channel window and sample offset, register NSAMP samples
module tap_delay_mux
  import beamform_cfg_pkg::*;
#(
  parameter int NCHAN = 8,
  parameter int NSAMP = 8,
  parameter int NBITS = 5,
  parameter int DEPTH = 10,
  parameter int FILL  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  tap_cfg_t                     cfg_i,
  input  logic [DEPTH*NSAMP*NBITS-1:0] win_i [NCHAN],
  output logic [NSAMP*NBITS-1:0]       tap_o
);

  localparam int MAXD = (DEPTH-1)*NSAMP;

  logic [DEPTH*NSAMP*NBITS-1:0] sel_win;
  logic [NSAMP*NBITS-1:0]       tap_d;
  logic [NSAMP*NBITS-1:0]       tap_q;

  // Window position MAXD+s is the current word's sample s; delay walks back from there.
  always_comb begin
    sel_win = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (int'(cfg_i.chan) == c) sel_win = win_i[c];
    end
    tap_d = '0;
    for (int s = 0; s < NSAMP; s++) begin
      if (cfg_i.en) tap_d[s*NBITS +: NBITS] = sel_win[(MAXD + s - int'(cfg_i.dly))*NBITS +: NBITS];
      else          tap_d[s*NBITS +: NBITS] = NBITS'(FILL);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tap_q <= '0;
    else       tap_q <= tap_d;
  end

  assign tap_o = tap_q;

endmodule

// File: rtl/subbeam_former_prog.sv
// rtl/subbeam_former_prog.sv - programmable sub-beam former: sample store, tap tables, commit FSM, adders
module subbeam_former_prog
  import beamform_cfg_pkg::*;
#(
  parameter int NCHAN   = 8,
  parameter int NSAMP   = 8,
  parameter int NBITS   = 5,
  parameter int DEPTH   = 10,
  parameter int NSUB    = 4,
  parameter int NTAP    = 3,
  parameter int FILL    = 4,
  parameter int SB_BITS = $clog2(NTAP*(2**NBITS-1)+1),
  parameter int AW      = $clog2(NSUB*NTAP)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0]  data_i,
  input  logic                          cfg_wr_i,
  input  logic [AW-1:0]                 cfg_addr_i,
  input  logic [15:0]                   cfg_dat_i,
  input  logic                          cfg_update_i,
  output logic                          cfg_busy_o,
  output logic                          cfg_err_o,
  output logic [NSUB*NSAMP*SB_BITS-1:0] dat_o,
  output logic                          dat_valid_o
);

  localparam int NTAB = NSUB*NTAP;
  localparam int MAXD = (DEPTH-1)*NSAMP;
  localparam int WW   = NSAMP*NBITS;
  localparam int FW   = $clog2(DEPTH+3);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH+2);

  logic [WW-1:0]       hist_q [NCHAN][DEPTH-1];
  logic [DEPTH*WW-1:0] win    [NCHAN];
  logic [WW-1:0]       tap_q  [NTAB];
  tap_cfg_t            shadow_q [NTAB];
  tap_cfg_t            active_q [NTAB];
  tap_cfg_t            wr_cfg;
  bf_state_t           state_q;
  logic                flush_q;
  logic                err_q;
  logic [FW-1:0]       fill_q;
  logic                wr_ok;
  logic                unused_cfg_bits;
  logic [SB_BITS-1:0]  acc;
  logic [NSUB*NSAMP*SB_BITS-1:0] sum_d;
  logic [NSUB*NSAMP*SB_BITS-1:0] sum_q;

  assign wr_cfg          = unpack_cfg(cfg_dat_i);
  assign wr_ok           = (int'(cfg_addr_i) < NTAB) && (int'(wr_cfg.chan) < NCHAN) &&
                           (int'(wr_cfg.dly) <= MAXD);
  assign unused_cfg_bits = ^cfg_dat_i[CFG_EN_BIT-1:CFG_CH_MSB+1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCHAN; c++)
        for (int k = 0; k < DEPTH-1; k++) hist_q[c][k] <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        hist_q[c][0] <= data_i[c*WW +: WW];
        for (int k = 1; k < DEPTH-1; k++) hist_q[c][k] <= hist_q[c][k-1];
      end
    end
  end

  // Oldest word at the bottom of each window, the live data_i word at the top.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      win[c] = '0;
      win[c][(DEPTH-1)*WW +: WW] = data_i[c*WW +: WW];
      for (int k = 0; k < DEPTH-1; k++) win[c][(DEPTH-2-k)*WW +: WW] = hist_q[c][k];
    end
  end

  for (genvar i = 0; i < NTAB; i++) begin : g_tap
    tap_delay_mux #(
      .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .DEPTH(DEPTH), .FILL(FILL)
    ) u_tap (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cfg_i (active_q[i]),
      .win_i (win),
      .tap_o (tap_q[i])
    );
  end

  always_comb begin
    sum_d = '0;
    acc   = '0;
    for (int b = 0; b < NSUB; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        acc = '0;
        for (int t = 0; t < NTAP; t++) acc = acc + SB_BITS'(tap_q[b*NTAP+t][s*NBITS +: NBITS]);
        sum_d[(b*NSAMP+s)*SB_BITS +: SB_BITS] = acc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  // A write in the same cycle as the update lands in shadow before COMMIT copies it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      fill_q  <= '0;
      for (int i = 0; i < NTAB; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
      case (state_q)
        ST_IDLE: begin
          if (cfg_update_i) begin
            state_q <= ST_COMMIT;
            err_q   <= 1'b0;
          end
          if (cfg_wr_i) begin
            if (wr_ok) shadow_q[cfg_addr_i] <= wr_cfg;
            else       err_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          active_q <= shadow_q;
          flush_q  <= 1'b0;
          state_q  <= ST_FLUSH;
        end
        ST_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (cfg_wr_i && state_q != ST_IDLE) err_q <= 1'b1;
    end
  end

  assign cfg_busy_o  = (state_q != ST_IDLE);
  assign cfg_err_o   = err_q;
  assign dat_o       = sum_q;
  assign dat_valid_o = (fill_q == FILL_MAX) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_subbeam_former_prog.sv
// tb/tb_subbeam_former_prog.sv - scoreboard bench for subbeam_former_prog
module tb_subbeam_former_prog;

  localparam int NCHAN = 8, NSAMP = 8, NBITS = 5, NSUB = 4, SB = 7;
  localparam int K_DAT = 0, K_VALID = 1, K_BUSY = 2, K_ERR = 3, K_ZERO = 4;

  typedef struct {
    int cyc;
    int kind;
    int sub;
    int samp;
    int val;
    int test;
  } exp_t;

  logic                         clk;
  logic                         rst;
  logic [NCHAN*NSAMP*NBITS-1:0] data;
  logic                         cfg_wr;
  logic [3:0]                   cfg_addr;
  logic [15:0]                  cfg_dat;
  logic                         cfg_update;
  logic                         cfg_busy;
  logic                         cfg_err;
  logic [NSUB*NSAMP*SB-1:0]     dat;
  logic                         dat_valid;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  subbeam_former_prog dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .cfg_wr_i     (cfg_wr),
    .cfg_addr_i   (cfg_addr),
    .cfg_dat_i    (cfg_dat),
    .cfg_update_i (cfg_update),
    .cfg_busy_o   (cfg_busy),
    .cfg_err_o    (cfg_err),
    .dat_o        (dat),
    .dat_valid_o  (dat_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_DAT:   return "dat_sample";
      K_VALID: return "dat_valid";
      K_BUSY:  return "cfg_busy";
      K_ERR:   return "cfg_err";
      default: return "dat_all_zero";
    endcase
  endfunction

  function automatic void push(int c, int k, int b, int s, int v, int t);
    exp_t e;
    e.cyc = c; e.kind = k; e.sub = b; e.samp = s; e.val = v; e.test = t;
    sb_q.push_back(e);
  endfunction

  task automatic check(input exp_t e);
    int act;
    case (e.kind)
      K_DAT:   act = dat_valid ? int'(dat[(e.sub*NSAMP+e.samp)*SB +: SB]) : -1;
      K_VALID: act = int'(dat_valid);
      K_BUSY:  act = int'(cfg_busy);
      K_ERR:   act = int'(cfg_err);
      default: act = (dat == '0) ? 0 : 1;
    endcase
    if (e.cyc != cyc) act = -2;
    n_cmp++;
    if (act != e.val) begin
      n_fail++;
      $display("FAIL test%0d %s sub%0d samp%0d cyc%0d: got %0d expected %0d",
               e.test, kname(e.kind), e.sub, e.samp, e.cyc, act, e.val);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        check(sb_q[i]);
        sb_q.delete(i);
      end
    end
  end

  function automatic logic [NCHAN*NSAMP*NBITS-1:0] idle_word();
    logic [NCHAN*NSAMP*NBITS-1:0] w;
    for (int i = 0; i < NCHAN*NSAMP; i++) w[i*NBITS +: NBITS] = 5'd4;
    return w;
  endfunction

  function automatic logic [NCHAN*NSAMP*NBITS-1:0] mk(int ch, int s, int v);
    logic [NCHAN*NSAMP*NBITS-1:0] w;
    logic [4:0] v5;
    w  = idle_word();
    v5 = v[4:0];
    w[(ch*NSAMP+s)*NBITS +: NBITS] = v5;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] d, input bit upd);
    cfg_wr     = 1'b1;
    cfg_addr   = addr[3:0];
    cfg_dat    = d;
    cfg_update = upd;
    tick(1);
    cfg_wr     = 1'b0;
    cfg_update = 1'b0;
  endtask

  task automatic do_commit(input int t);
    int u;
    u = cyc;
    push(u+1, K_BUSY, 0, 0, 1, t);
    push(u+2, K_VALID, 0, 0, 0, t);
    push(u+3, K_BUSY, 0, 0, 1, t);
    push(u+4, K_BUSY, 0, 0, 0, t);
    push(u+4, K_VALID, 0, 0, 1, t);
    cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    tick(3);
  endtask

  initial begin
    int r, t, u, w;
    rst = 1'b1; data = idle_word(); cfg_wr = 1'b0; cfg_addr = '0; cfg_dat = '0; cfg_update = 1'b0;
    tick(3);

    // 1: reset state and fill latency
    push(cyc, K_ZERO, 0, 0, 0, 1);
    push(cyc, K_VALID, 0, 0, 0, 1);
    push(cyc, K_BUSY, 0, 0, 0, 1);
    push(cyc, K_ERR, 0, 0, 0, 1);
    r = cyc;
    rst = 1'b0;
    push(r+11, K_VALID, 0, 0, 0, 1);
    push(r+12, K_VALID, 0, 0, 1, 1);
    for (int b = 0; b < NSUB; b++)
      for (int s = 0; s < NSAMP; s++) push(r+12, K_DAT, b, s, 12, 1);
    tick(13);

    // 2: sub0 = ch1/ch2/ch3 at d=0
    cfg_write(0, 16'h8100, 1'b0);
    cfg_write(1, 16'h8200, 1'b0);
    cfg_write(2, 16'h8300, 1'b0);
    do_commit(2);
    t = cyc;
    data = mk(1, 3, 31);
    push(t+2, K_DAT, 0, 3, 39, 2);
    push(t+2, K_DAT, 0, 2, 12, 2);
    push(t+2, K_DAT, 0, 4, 12, 2);
    push(t+3, K_DAT, 0, 3, 12, 2);
    push(t+2, K_DAT, 1, 3, 12, 2);
    tick(1);
    data = idle_word();
    tick(4);

    // 3: sub1 tap0 = ch5 d=11
    cfg_write(3, 16'h850B, 1'b0);
    do_commit(3);
    t = cyc;
    data = mk(5, 3, 31);
    push(t+3, K_DAT, 1, 6, 39, 3);
    push(t+2, K_DAT, 1, 6, 12, 3);
    push(t+3, K_DAT, 1, 3, 12, 3);
    push(t+4, K_DAT, 1, 6, 12, 3);
    tick(1);
    data = idle_word();
    tick(5);

    // 4: rejected writes, boundary delay MAXD=72, sticky error cleared by update
    w = cyc;
    push(w, K_ERR, 0, 0, 0, 4);
    cfg_write(7, 16'h8050, 1'b0);
    push(w+1, K_ERR, 0, 0, 1, 4);
    cfg_write(6, 16'h8048, 1'b0);
    push(w+2, K_ERR, 0, 0, 1, 4);
    cfg_write(8, 16'h8800, 1'b0);
    cfg_write(13, 16'h8100, 1'b0);
    push(cyc+1, K_ERR, 0, 0, 0, 4);
    do_commit(4);
    t = cyc;
    data = mk(0, 0, 31);
    push(t+10, K_DAT, 2, 0, 12, 4);
    push(t+11, K_DAT, 2, 0, 39, 4);
    push(t+11, K_DAT, 2, 1, 12, 4);
    push(t+11, K_DAT, 3, 0, 12, 4);
    tick(1);
    data = idle_word();
    tick(12);

    // 5: write during FLUSH ignored; write+update in one IDLE cycle is committed
    u = cyc;
    cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    tick(1);
    cfg_write(9, 16'h8100, 1'b0);
    push(u+3, K_ERR, 0, 0, 1, 5);
    push(u+3, K_BUSY, 0, 0, 1, 5);
    tick(1);
    w = cyc;
    cfg_write(10, 16'h8200, 1'b1);
    push(w+1, K_ERR, 0, 0, 0, 5);
    push(w+1, K_BUSY, 0, 0, 1, 5);
    tick(4);
    t = cyc;
    data = mk(1, 3, 31);
    data[(2*NSAMP+5)*NBITS +: NBITS] = 5'd31;
    push(t+2, K_DAT, 3, 3, 12, 5);
    push(t+2, K_DAT, 3, 5, 39, 5);
    push(t+2, K_DAT, 0, 3, 39, 5);
    push(t+2, K_DAT, 0, 5, 39, 5);
    tick(1);
    data = idle_word();
    tick(4);

    // 6: reset during FLUSH clears everything, no partial commit
    u = cyc;
    cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    cfg_write(11, 16'h8300, 1'b0);
    push(u+2, K_ERR, 0, 0, 1, 6);
    push(u+2, K_BUSY, 0, 0, 1, 6);
    tick(1);
    rst = 1'b1;
    push(cyc, K_ZERO, 0, 0, 0, 6);
    push(cyc, K_VALID, 0, 0, 0, 6);
    push(cyc, K_BUSY, 0, 0, 0, 6);
    push(cyc, K_ERR, 0, 0, 0, 6);
    tick(2);
    r = cyc;
    rst = 1'b0;
    push(r+11, K_VALID, 0, 0, 0, 6);
    push(r+12, K_VALID, 0, 0, 1, 6);
    tick(12);
    t = cyc;
    data = mk(1, 3, 31);
    data[(5*NSAMP+3)*NBITS +: NBITS] = 5'd31;
    push(t+2, K_DAT, 0, 3, 12, 6);
    push(t+3, K_DAT, 1, 6, 12, 6);
    push(t+2, K_DAT, 3, 5, 12, 6);
    tick(1);
    data = idle_word();
    tick(5);

    while (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL test%0d %s never_checked: got none expected %0d",
               sb_q[0].test, kname(sb_q[0].kind), sb_q[0].val);
      sb_q.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
